// File: rtl/uart_param_txrx_if.sv
// uart_param_txrx_if: serial pins plus TX/RX handshake signals of uart_param_txrx
// master: bus owner (drives tx_data_in, start, rx); slave: the UART core
interface uart_param_txrx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] tx_data_in;
  logic start;
  logic tx;
  logic tx_active;
  logic done_tx;
  logic rx;
  logic [DATA_WIDTH-1:0] rx_data_out;
  logic rx_valid;
  logic rx_frame_err;
  logic rx_parity_err;
  modport master (
    output tx_data_in, start, rx,
    input  tx, tx_active, done_tx, rx_data_out, rx_valid, rx_frame_err, rx_parity_err
  );
  modport slave (
    input  tx_data_in, start, rx,
    output tx, tx_active, done_tx, rx_data_out, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_param_txrx.sv
// uart_param_txrx: parametrised full-duplex UART core, LSB-first, 1 start bit, DATA_WIDTH data bits
// Ports: clk, rst_n (async active-low); bus (slave modport):
//   TX side  tx_data_in, start -> tx (serial, idle high), tx_active, done_tx
//   RX side  rx (async serial) -> rx_data_out, rx_valid, rx_frame_err, rx_parity_err
// Build option: define UART_PARITY_EN to add a parity bit (^data ^ PARITY_ODD) after the data bits
module uart_param_txrx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic clk,
  input logic rst_n,
  uart_param_txrx_if.slave bus
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(STOP_BITS * CPB);
  localparam int BW  = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
  state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic tx_bit_end, tx_stop_end, tx_accept;
  assign tx_bit_end  = tx_cnt_q == CW'(CPB - 1);
  assign tx_stop_end = tx_state_q == S_STOP && tx_cnt_q == CW'(STOP_BITS * CPB - 1);
  // the last stop cycle counts as idle so a held start chains frames with no gap
  assign tx_accept   = bus.start && (tx_state_q == S_IDLE || tx_stop_end);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_buf_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_buf_q   <= tx_buf_d;
    end
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_buf_d   = tx_buf_q;
    case (tx_state_q)
      S_IDLE: tx_cnt_d = '0;
      S_START: if (tx_bit_end) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end
      // rotate so bit 0 is always on the line; a full rotation restores the byte
      S_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 1'b1;
        tx_buf_d = {tx_buf_q[0], tx_buf_q[DATA_WIDTH-1:1]};
        if (tx_bit_q == BW'(DATA_WIDTH - 1))
`ifdef UART_PARITY_EN
          tx_state_d = S_PARITY;
`else
          tx_state_d = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tx_bit_end) begin
        tx_state_d = S_STOP;
        tx_cnt_d   = '0;
      end
`endif
      S_STOP: if (tx_stop_end) begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_accept) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_buf_d   = bus.tx_data_in;
    end
  end
  always_comb begin
    bus.tx = 1'b1;
    if (tx_state_q == S_START) bus.tx = 1'b0;
    if (tx_state_q == S_DATA) bus.tx = tx_buf_q[0];
`ifdef UART_PARITY_EN
    if (tx_state_q == S_PARITY) bus.tx = ^tx_buf_q ^ 1'(PARITY_ODD);
`endif
    bus.done_tx   = tx_stop_end;
    bus.tx_active = tx_state_q != S_IDLE && !tx_stop_end;
  end
  state_t rx_state_q, rx_state_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d, rx_sample;
`ifdef UART_PARITY_EN
  logic rx_par_q, rx_par_d, rx_perr_q, rx_perr_d;
`endif
  // half a bit after the falling edge in START, then a full bit between samples
  assign rx_sample = rx_cnt_q == (rx_state_q == S_START ? CW'(CPB / 2 - 1) : CW'(CPB - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= bus.rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_sample ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = rx_ferr_q;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      // a 1->0 edge is required, so a line stuck low after a frame error never retriggers
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: if (rx_sample) begin
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_bit_d   = '0;
      end
      S_DATA: if (rx_sample) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == BW'(DATA_WIDTH - 1))
`ifdef UART_PARITY_EN
          rx_state_d = S_PARITY;
`else
          rx_state_d = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (rx_sample) begin
        rx_par_d   = rx_s2_q;
        rx_state_d = S_STOP;
      end
`endif
      S_STOP: if (rx_sample) begin
        rx_data_d  = rx_shift_q;
        rx_ferr_d  = ~rx_s2_q;
        rx_valid_d = 1'b1;
        rx_state_d = S_IDLE;
`ifdef UART_PARITY_EN
        rx_perr_d  = (^rx_shift_q ^ 1'(PARITY_ODD)) != rx_par_q;
`endif
      end
      default: rx_state_d = S_IDLE;
    endcase
  end
  always_comb begin
    bus.rx_data_out  = rx_data_q;
    bus.rx_valid     = rx_valid_q;
    bus.rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    bus.rx_parity_err = rx_perr_q;
`else
    bus.rx_parity_err = 1'b0;
`endif
  end
endmodule

// File: tb/tb_uart_param_txrx.sv
// tb_uart_param_txrx: directed + random frames checked against a frame-level reference model
module tb_uart_param_txrx;
  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int SB  = 1;
  localparam int ODD = 0;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DW + PB + SB;
  typedef struct packed {
    logic [DW-1:0] d;
    logic fe;
    logic pe;
  } rx_exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop = 1'b1;
  logic rx_drv = 1'b1;
  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int ndone = 0;
  int n0, d0;
  rx_exp_t exp_q[$];
  rx_exp_t e;
  uart_param_txrx_if #(.DATA_WIDTH(DW)) bus();
  uart_param_txrx #(
    .CLK_FREQ(CPB * 10), .BAUD_RATE(10), .DATA_WIDTH(DW), .STOP_BITS(SB), .PARITY_ODD(ODD)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.rx = loop ? bus.tx : rx_drv;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // line level of bit k of a frame carrying d
  function automatic logic frame_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    if (PB == 1 && k == DW + 1) return ^d ^ 1'(ODD);
    return 1'b1;
  endfunction
  always @(negedge clk) begin
    if (bus.done_tx) ndone++;
    if (bus.rx_valid) begin
      nvalid++;
      if (exp_q.size() == 0) chk("rx_unexpected", 32'(bus.rx_valid), 0);
      else begin
        e = exp_q.pop_front();
        chk("rx_data", 32'(bus.rx_data_out), 32'(e.d));
        chk("rx_frame_err", 32'(bus.rx_frame_err), 32'(e.fe));
        chk("rx_parity_err", 32'(bus.rx_parity_err), 32'(e.pe));
      end
    end
  end
  // chained: the previous call left start high with d already on tx_data_in
  task automatic send(input logic [DW-1:0] d, input bit keep, input logic [DW-1:0] nxt, input bit chained);
    if (!chained) begin
      @(negedge clk);
      bus.tx_data_in = d;
      bus.start = 1'b1;
    end
    if (loop) exp_q.push_back('{d, 1'b0, 1'b0});
    for (int i = 1; i <= NB * CPB; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = keep;
        bus.tx_data_in = keep ? nxt : DW'($urandom);
        chk("tx_start_edge", 32'(bus.tx), 0);
        chk("tx_active_on", 32'(bus.tx_active), 1);
      end
      if (i % CPB == CPB / 2) chk($sformatf("tx_bit%0d", i / CPB), 32'(bus.tx), 32'(frame_bit(d, i / CPB)));
      if (i == NB * CPB - 1) chk("done_early", 32'(bus.done_tx), 0);
      if (i == NB * CPB) begin
        chk("done_tx", 32'(bus.done_tx), 1);
        chk("tx_active_off", 32'(bus.tx_active), 0);
      end
    end
  endtask
  task automatic inject(input logic [DW-1:0] d, input logic stop, input logic par);
    loop = 1'b0;
    exp_q.push_back('{d, ~stop, PB == 1 && par != (^d ^ 1'(ODD))});
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      rx_drv = (k == NB - SB) ? stop : (PB == 1 && k == DW + 1) ? par : frame_bit(d, k);
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.tx_data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(bus.tx), 1);
    chk("rst_tx_active", 32'(bus.tx_active), 0);
    chk("rst_done_tx", 32'(bus.done_tx), 0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_rx_data", 32'(bus.rx_data_out), 0);
    chk("rst_ferr", 32'(bus.rx_frame_err), 0);
    chk("rst_perr", 32'(bus.rx_parity_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'hA5, 1'b0, '0, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("pending_a5", exp_q.size(), 0);
    send(8'h00, 1'b1, 8'hFF, 1'b0);
    send(8'hFF, 1'b1, 8'h3C, 1'b1);
    send(8'h3C, 1'b0, '0, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("pending_b2b", exp_q.size(), 0);
    for (int r = 0; r < 3; r++) send(DW'($urandom), 1'b0, '0, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("pending_rand", exp_q.size(), 0);
    loop = 1'b0;
    n0 = nvalid;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (CPB / 2 - 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_valid", nvalid, n0);
    inject(8'h5A, 1'b0, ^8'h5A);
    chk("ferr_held", 32'(bus.rx_frame_err), 1);
    inject(8'h11, 1'b1, ^8'h11);
    chk("ferr_cleared", 32'(bus.rx_frame_err), 0);
`ifdef UART_PARITY_EN
    inject(8'h07, 1'b1, 1'b0);
    chk("perr_held", 32'(bus.rx_parity_err), 1);
`endif
    for (int r = 0; r < 2; r++) begin
      e.d = DW'($urandom);
      inject(e.d, 1'b1, ^e.d ^ 1'(ODD));
    end
    chk("pending_inject", exp_q.size(), 0);
    loop = 1'b1;
    @(negedge clk);
    bus.tx_data_in = 8'hC3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4 * CPB + CPB / 2 - 1) @(negedge clk);
    chk("pre_rst_bit3", 32'(bus.tx), 0);
    d0 = ndone;
    n0 = nvalid;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(bus.tx), 1);
    chk("midrst_tx_active", 32'(bus.tx_active), 0);
    chk("midrst_rx_data", 32'(bus.rx_data_out), 0);
    repeat (CPB) @(negedge clk);
    rst_n = 1'b1;
    repeat (NB * CPB) @(negedge clk);
    chk("midrst_no_done", ndone, d0);
    chk("midrst_no_valid", nvalid, n0);
    send(8'h81, 1'b0, '0, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("pending_final", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
